// File: rtl/w5300_pkg.sv
// W5300 register map, bus-op encoding and receiver state type shared by the socket engines.
package w5300_pkg;

    localparam logic OP_RD = 1'b1;
    localparam logic OP_WR = 1'b0;

    localparam logic [9:0] SOCK_BASE   = 10'h200;
    localparam logic [9:0] SOCK_STRIDE = 10'h040;
    localparam logic [9:0] SN_CR       = 10'h002;
    localparam logic [9:0] SN_RX_RSR0  = 10'h028;
    localparam logic [9:0] SN_RX_RSR1  = 10'h02a;
    localparam logic [9:0] SN_RX_FIFOR = 10'h030;
    localparam logic [9:0] IDR_REG     = 10'h3fe;

    localparam logic [15:0] CMD_RECV = 16'h0040;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSR_HI,
        ST_RSR_LO,
        ST_PKT_LEN,
        ST_DATA,
        ST_RECV,
        ST_FINISH
    } rx_state_e;

    // Absolute register address of a socket-relative offset.
    function automatic logic [9:0] sock_reg(input int unsigned n, input logic [9:0] off);
        return SOCK_BASE + 10'(n) * SOCK_STRIDE + off;
    endfunction

endpackage

// File: rtl/w5300_receiver.sv
// Drains one packet from a W5300 socket RX FIFO into a word buffer, then issues RECV.
module w5300_receiver
    import w5300_pkg::*;
#(
    parameter int unsigned N                   = 0,
    parameter int unsigned ETH_RX_BUFFER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [10:0]                    addr,
    output logic [15:0]                    wr_data,
    input  logic [15:0]                    rd_data,
    input  logic                           op_state,
    output logic                           eth_rx_buffer_wr,
    output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
    output logic [15:0]                    eth_rx_buffer_data,
    output logic                           eth_rx_req,
    output logic [15:0]                    eth_rx_len,
    output logic                           overflow
);

    localparam int unsigned BW = ETH_RX_BUFFER_WIDTH;
    // Counter is wide enough to hold the buffer capacity and any 16-bit word count.
    localparam int unsigned CW = (BW + 1 > 17) ? BW + 1 : 17;
    localparam logic [CW-1:0] CAP = CW'(1) << BW;

    localparam logic [10:0] A_IDLE  = {OP_RD, IDR_REG};
    localparam logic [10:0] A_RSR0  = {OP_RD, sock_reg(N, SN_RX_RSR0)};
    localparam logic [10:0] A_RSR1  = {OP_RD, sock_reg(N, SN_RX_RSR1)};
    localparam logic [10:0] A_FIFOR = {OP_RD, sock_reg(N, SN_RX_FIFOR)};
    localparam logic [10:0] A_CR    = {OP_WR, sock_reg(N, SN_CR)};

    rx_state_e       state;
    logic            rsr_hi;
    logic [CW-1:0]   words;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            addr               <= A_IDLE;
            wr_data            <= 16'h0000;
            eth_rx_buffer_wr   <= 1'b0;
            eth_rx_buffer_addr <= '0;
            eth_rx_buffer_data <= 16'h0000;
            eth_rx_req         <= 1'b0;
            eth_rx_len         <= 16'h0000;
            overflow           <= 1'b0;
            rsr_hi             <= 1'b0;
            words              <= '0;
            cnt                <= '0;
        end else begin
            done             <= 1'b0;
            eth_rx_req       <= 1'b0;
            eth_rx_buffer_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RSR_HI;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        addr     <= A_RSR0;
                    end
                end
                ST_RSR_HI: begin
                    if (op_state) begin
                        rsr_hi <= rd_data[0];
                        addr   <= A_RSR1;
                        state  <= ST_RSR_LO;
                    end
                end
                ST_RSR_LO: begin
                    if (op_state) begin
                        if ({rsr_hi, rd_data} == 17'd0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            addr  <= A_IDLE;
                        end else begin
                            state <= ST_PKT_LEN;
                            addr  <= A_FIFOR;
                        end
                    end
                end
                ST_PKT_LEN: begin
                    if (op_state) begin
                        eth_rx_len <= rd_data;
                        words      <= CW'((17'(rd_data) + 17'd1) >> 1);
                        cnt        <= '0;
                        if (rd_data == 16'h0000) begin
                            state   <= ST_RECV;
                            addr    <= A_CR;
                            wr_data <= CMD_RECV;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (op_state) begin
                        // Words beyond buffer capacity are still read so the FIFO drains.
                        if (cnt < CAP) begin
                            eth_rx_buffer_wr   <= 1'b1;
                            eth_rx_buffer_addr <= cnt[BW-1:0];
                            eth_rx_buffer_data <= rd_data;
                        end else begin
                            overflow <= 1'b1;
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == words - CW'(1)) begin
                            state   <= ST_RECV;
                            addr    <= A_CR;
                            wr_data <= CMD_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (op_state) begin
                        state      <= ST_FINISH;
                        done       <= 1'b1;
                        eth_rx_req <= (eth_rx_len != 16'h0000);
                        addr       <= A_IDLE;
                        wr_data    <= 16'h0000;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_receiver.sv
// Bench for w5300_receiver: random-latency bus responder plus packet-level reference model.
module tb_w5300_receiver;

    localparam int unsigned BW  = 2;
    localparam int unsigned CAP = 4;

    localparam logic [10:0] A_IDLE  = 11'h7fe;
    localparam logic [10:0] A_RSR0  = 11'h668;
    localparam logic [10:0] A_RSR1  = 11'h66a;
    localparam logic [10:0] A_FIFOR = 11'h670;
    localparam logic [10:0] A_CR    = 11'h242;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [10:0]   addr;
    logic [15:0]   wr_data;
    logic [15:0]   rd_data = 16'h0000;
    logic          op_state = 1'b0;
    logic          eth_rx_buffer_wr;
    logic [BW-1:0] eth_rx_buffer_addr;
    logic [15:0]   eth_rx_buffer_data;
    logic          eth_rx_req;
    logic [15:0]   eth_rx_len;
    logic          overflow;

    w5300_receiver #(.N(1), .ETH_RX_BUFFER_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .op_state(op_state),
        .eth_rx_buffer_wr(eth_rx_buffer_wr), .eth_rx_buffer_addr(eth_rx_buffer_addr),
        .eth_rx_buffer_data(eth_rx_buffer_data), .eth_rx_req(eth_rx_req),
        .eth_rx_len(eth_rx_len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] fifo_mem [0:4095];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic [16:0] cur_rsr = 17'd0;

    logic [10:0] op_addr_q [$];
    logic [15:0] op_data_q [$];
    int          wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    bit          wr_lat_q  [$];
    int          done_cnt = 0;
    int          req_cnt = 0;
    int          req_nodone = 0;
    time         last_fifo_t = 0;
    logic [15:0] last_fifo_d = 16'h0000;

    logic [15:0] pkt_d [$];
    int          exp_len = 0;

    // W5300 bus side: completes ops after a random wait, serving RSR and FIFO contents.
    always @(negedge clk) begin
        if (!rst_n) begin
            op_state = 1'b0;
            fifo_rd  = fifo_wr;
        end else if (op_state) begin
            op_state = 1'b0;
            rd_data  = 16'($urandom);
        end else if ($urandom_range(0, 2) == 0) begin
            op_state = 1'b1;
            if (addr == A_RSR0) begin
                rd_data = {15'($urandom), cur_rsr[16]};
            end else if (addr == A_RSR1) begin
                rd_data = cur_rsr[15:0];
            end else if (addr == A_FIFOR) begin
                rd_data     = fifo_mem[fifo_rd % 4096];
                fifo_rd     = fifo_rd + 1;
                last_fifo_t = $time;
                last_fifo_d = rd_data;
            end else begin
                rd_data = 16'($urandom);
            end
            if (addr != A_IDLE) begin
                op_addr_q.push_back(addr);
                op_data_q.push_back(wr_data);
            end
        end
    end

    // Output monitor; write latency is judged against the FIFO op one cycle earlier.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (eth_rx_req) begin
                req_cnt++;
                if (!done) req_nodone++;
            end
            if (eth_rx_buffer_wr) begin
                wr_addr_q.push_back(int'(eth_rx_buffer_addr));
                wr_data_q.push_back(eth_rx_buffer_data);
                wr_lat_q.push_back((last_fifo_t == $time - 10) && (last_fifo_d == eth_rx_buffer_data));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen_data(input int len);
        pkt_d.delete();
        for (int i = 0; i < (len + 1) / 2; i++) pkt_d.push_back(16'($urandom));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_wr"}, 32'(eth_rx_buffer_wr), 0);
        chk({tag, "_req"}, 32'(eth_rx_req), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_len"}, 32'(eth_rx_len), 0);
        chk({tag, "_baddr"}, 32'(eth_rx_buffer_addr), 0);
        chk({tag, "_bdata"}, 32'(eth_rx_buffer_data), 0);
        chk({tag, "_addr"}, 32'(addr), 32'(A_IDLE));
    endtask

    // One start-to-done transaction checked against the packet model; pkt_d holds the payload.
    task automatic run_packet(input string tag, input logic [16:0] rsr, input int len, input bit restart);
        int words, op0, wr0, d0, r0, rn0, cyc, n_wr, exp_req;
        bit ovf;
        logic [10:0] ea [$];
        logic [15:0] ed [$];
        words = (len + 1) / 2;
        if (rsr != 17'd0) begin
            fifo_mem[fifo_wr % 4096] = 16'(len);
            fifo_wr++;
            for (int i = 0; i < words; i++) begin
                fifo_mem[fifo_wr % 4096] = pkt_d[i];
                fifo_wr++;
            end
        end
        cur_rsr = rsr;
        op0 = op_addr_q.size(); wr0 = wr_addr_q.size();
        d0 = done_cnt; r0 = req_cnt; rn0 = req_nodone;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy), 1);
        chk({tag, "_ovf_cleared"}, 32'(overflow), 0);
        if (restart) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_no_timeout"}, 32'(cyc < 2000), 1);
        repeat (12) @(negedge clk);

        ea.push_back(A_RSR0); ed.push_back(16'h0);
        ea.push_back(A_RSR1); ed.push_back(16'h0);
        if (rsr != 17'd0) begin
            for (int i = 0; i <= words; i++) begin
                ea.push_back(A_FIFOR); ed.push_back(16'h0);
            end
            ea.push_back(A_CR); ed.push_back(16'h0040);
            exp_len = len;
        end
        exp_req = (rsr != 17'd0 && len > 0) ? 1 : 0;
        ovf     = (rsr != 17'd0) && (words > CAP);
        n_wr    = (rsr == 17'd0) ? 0 : ((words > CAP) ? CAP : words);

        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
        chk({tag, "_req_pulses"}, 32'(req_cnt - r0), 32'(exp_req));
        chk({tag, "_req_without_done"}, 32'(req_nodone - rn0), 0);
        chk({tag, "_busy_end"}, 32'(busy), 0);
        chk({tag, "_rx_len"}, 32'(eth_rx_len), 32'(exp_len));
        chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
        chk({tag, "_op_count"}, 32'(op_addr_q.size() - op0), 32'(ea.size()));
        for (int i = 0; i < ea.size() && op0 + i < op_addr_q.size(); i++) begin
            chk({tag, "_op_addr"}, 32'(op_addr_q[op0 + i]), 32'(ea[i]));
            if (ea[i][10] == 1'b0) chk({tag, "_op_wdata"}, 32'(op_data_q[op0 + i]), 32'(ed[i]));
        end
        chk({tag, "_wr_count"}, 32'(wr_addr_q.size() - wr0), 32'(n_wr));
        for (int i = 0; i < n_wr && wr0 + i < wr_addr_q.size(); i++) begin
            chk({tag, "_wr_addr"}, 32'(wr_addr_q[wr0 + i]), 32'(i));
            chk({tag, "_wr_data"}, 32'(wr_data_q[wr0 + i]), 32'(pkt_d[i]));
            chk({tag, "_wr_latency"}, 32'(wr_lat_q[wr0 + i]), 1);
        end
    endtask

    initial begin
        int op0, wr0, cyc, n_cr, len;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        pkt_d.delete();
        run_packet("rsr_zero", 17'd0, 0, 1'b0);

        pkt_d.delete();
        pkt_d.push_back(16'h1122); pkt_d.push_back(16'h3344); pkt_d.push_back(16'h5566);
        run_packet("len6", 17'd8, 6, 1'b0);

        gen_data(5);
        run_packet("len5_odd", 17'd7, 5, 1'b0);

        gen_data(12);
        run_packet("len12_overflow", 17'd14, 12, 1'b0);

        gen_data(4);
        run_packet("ovf_clear_next", 17'd6, 4, 1'b0);

        gen_data(8);
        run_packet("rsr_bit16", 17'h10000, 8, 1'b0);

        pkt_d.delete();
        run_packet("len_zero", 17'd2, 0, 1'b0);

        gen_data(6);
        run_packet("start_while_busy", 17'd8, 6, 1'b1);

        // Reset in the middle of Data after two words.
        gen_data(12);
        fifo_mem[fifo_wr % 4096] = 16'd12;
        fifo_wr++;
        for (int i = 0; i < 6; i++) begin
            fifo_mem[fifo_wr % 4096] = pkt_d[i];
            fifo_wr++;
        end
        cur_rsr = 17'd14;
        op0 = op_addr_q.size(); wr0 = wr_addr_q.size();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (wr_addr_q.size() < wr0 + 2 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midreset_two_words", 32'(cyc < 2000), 1);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        n_cr = 0;
        for (int i = op0; i < op_addr_q.size(); i++) if (op_addr_q[i] == A_CR) n_cr++;
        chk("midreset_no_recv", 32'(n_cr), 0);
        exp_len = 0;
        repeat (2) @(negedge clk);
        gen_data(6);
        run_packet("after_reset", 17'd8, 6, 1'b0);

        for (int k = 0; k < 16; k++) begin
            len = int'($urandom_range(0, 20));
            gen_data(len);
            if ($urandom_range(0, 3) == 0) run_packet("random", 17'd0, len, 1'b0);
            else run_packet("random", 17'(len + 2), len, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/w5300_receiver.md
W5300_RECEIVER -- requirements
Module: w5300_receiver

Interface
REQ-001 SHALL have parameter N, default 0, meaning W5300 socket index 0..7; socket register base = 0x200 + N*0x40.
REQ-002 SHALL have parameter ETH_RX_BUFFER_WIDTH, default 16, meaning the RX buffer word-address width.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to drain one packet; ignored unless idle.
REQ-006 SHALL have port busy, output, 1, high from start acceptance until done.
REQ-007 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port addr, output, 11, bus-op address to w5300_interface; bit10 = RD(1)/WR(0), bits9:0 = register.
REQ-009 SHALL have port wr_data, output, 16, write data for WR ops.
REQ-010 SHALL have port rd_data, input, 16, read data from w5300_interface.
REQ-011 SHALL have port op_state, input, 1, one-cycle pulse when the current bus op completes; rd_data is valid in that cycle.
REQ-012 SHALL have port eth_rx_buffer_wr, output, 1, buffer write strobe.
REQ-013 SHALL have port eth_rx_buffer_addr, output, ETH_RX_BUFFER_WIDTH, buffer word address.
REQ-014 SHALL have port eth_rx_buffer_data, output, 16, buffer write data.
REQ-015 SHALL have port eth_rx_req, output, 1, one-cycle pulse announcing a packet in the buffer.
REQ-016 SHALL have port eth_rx_len, output, 16, packet byte length; held until the next packet.
REQ-017 SHALL have port overflow, output, 1, sticky flag: the last packet exceeded buffer capacity; cleared on start.

Function
REQ-018 SHALL implement FSM states Idle, RsrHi, RsrLo, PktLen, Data, Recv, Finish.
REQ-019 SHALL hold addr and wr_data constant for the whole of each state; advance only on op_state.
REQ-020 Idle: addr = {RD, 10'h3fe}; on start -> RsrHi, clear overflow.
REQ-021 RsrHi: read Sn_RX_RSR0; latch rsr[16], ignore other bits; -> RsrLo.
REQ-022 RsrLo: read Sn_RX_RSR1; latch rsr[15:0]; if the 17-bit rsr == 0 -> Finish (no RECV command, no eth_rx_req), else -> PktLen.
REQ-023 PktLen: read Sn_RX_FIFOR; latch length into eth_rx_len and words = (len+1)>>1 (17-bit arithmetic); word counter := 0; if len == 0 -> Recv, else -> Data.
REQ-024 Data: read Sn_RX_FIFOR per op; on each op_state assert eth_rx_buffer_wr for one cycle with data = rd_data and addr = counter[ETH_RX_BUFFER_WIDTH-1:0]; increment counter.
REQ-025 Data: if counter >= 2**ETH_RX_BUFFER_WIDTH, suppress the write, still read the word (drain), and set overflow.
REQ-026 Data: after the op_state for word words-1 -> Recv.
REQ-027 Recv: write Sn_CR = 0x40 (RECV); on op_state -> Finish.
REQ-028 Finish: pulse done for one cycle; pulse eth_rx_req in the same cycle iff a packet was read (len > 0 path); -> Idle.
REQ-029 SHALL ignore op_state while in Idle or Finish.
REQ-030 SHALL ignore start while busy; at most one packet per start.
REQ-031 SHALL ensure write-strobe latency = 1 cycle after the op_state that carries the word (registered outputs).

Reset
REQ-032 On rst_n low, SHALL immediately enter Idle and clear busy, done, eth_rx_buffer_wr, eth_rx_req, overflow, counters, and eth_rx_len; eth_rx_buffer_addr and eth_rx_buffer_data SHALL be 0.
REQ-033 SHALL abandon a packet read in progress at reset without issuing RECV; recovery is by W5300 re-initialisation from the driver top.

Structure
REQ-034 SHALL source the RD/WR encoding, Sn_CR, Sn_RX_RSR0/1, Sn_RX_FIFOR offsets, socket base/stride, and the RECV command code from package W5300.
REQ-035 SHALL be a single module with no sub-modules; instantiated by the driver top and muxed onto the bus in the Receiving state.

Verification
REQ-036 RSR = 0x0000_0000 with start -> two reads, done pulse, no eth_rx_req, no RECV write.
REQ-037 RSR = 8, FIFO words 0x0006, 0x1122, 0x3344, 0x5566 -> 3 buffer writes at addresses 0..2 with those words, RECV write of 0x40 to Sn_CR, eth_rx_len = 6, eth_rx_req together with done.
REQ-038 Odd length 5 -> 3 data reads/writes; eth_rx_len = 5.
REQ-039 ETH_RX_BUFFER_WIDTH = 2, length 12 -> 6 reads, only 4 writes (addresses 0..3), overflow = 1, RECV still issued.
REQ-040 Reset asserted during Data after 2 words -> all outputs 0 and Idle the next cycle; a new start runs a clean sequence.
REQ-041 start pulsed again while busy -> ignored; exactly one done pulse.
